// File: rtl/bin_cnt_bhvl.sv
// Free-running WIDTH-bit binary up-counter with asynchronous active-high reset.
// Wraps modulo 2**WIDTH; the output is taken straight from the state register.
module bin_cnt_bhvl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] counter
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Carry out of the add is dropped, so the top value rolls over to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      counter <= '0;
    else
      counter <= counter + ONE;
  end

endmodule

// File: tb/tb_bin_cnt_bhvl.sv
// Directed and randomized checks of bin_cnt_bhvl at WIDTH=4 and WIDTH=3
// against a model that counts edges since reset release.
module tb_bin_cnt_bhvl;

  logic       clk;
  logic       rst;
  logic [3:0] cnt4;
  logic [2:0] cnt3;

  int checks;
  int errors;
  int edges;

  bin_cnt_bhvl #(.WIDTH(4)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .counter (cnt4)
  );

  bin_cnt_bhvl #(.WIDTH(3)) dut3 (
    .clk     (clk),
    .rst     (rst),
    .counter (cnt3)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected value is simply the number of counted edges modulo 2**W.
  task automatic check_both(input string tag);
    logic [3:0] e4;
    logic [3:0] e3;
    e4 = 4'(edges % 16);
    e3 = 4'(edges % 8);
    check({tag, "_w4"}, cnt4, e4);
    check({tag, "_w3"}, {1'b0, cnt3}, e3);
  endtask

  task automatic step(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!rst) edges++;
      #1;
      check_both(tag);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    edges = 0;
    #1;
    check_both("rst_assert");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    edges  = 0;
    rst    = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_both("reset_settle");

    // Hold reset for 200 ns, sampling away from edges.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_both("reset_hold");
    end
    rst = 1'b0;
    step(5, "release_seq");

    // Wrap: 16 edges from 0 gives 0 at WIDTH=4, then 1.
    do_reset();
    step(17, "wrap");

    // Asynchronous reset mid-period at counter==9.
    do_reset();
    step(9, "to_nine");
    #5;
    rst = 1'b1;
    edges = 0;
    #1;
    check_both("async_mid");
    step(10, "hold_high");
    @(negedge clk);
    rst = 1'b0;
    step(1, "after_hold");

    // Randomized runs with asynchronous resets at random offsets.
    for (int r = 0; r < 20; r++) begin
      step(int'($urandom_range(0, 40)), "rand_run");
      @(posedge clk);
      if (!rst) edges++;
      #($urandom_range(2, 8));
      rst = 1'b1;
      edges = 0;
      #1;
      check_both("rand_async");
      step(int'($urandom_range(0, 3)), "rand_hold");
      @(negedge clk);
      rst = 1'b0;
    end
    step(3, "final_run");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
